iir_requant_decim: RTL

IIR_REQUANT_DECIM -- requirements
Module: iir_requant_decim

---
 rtl/iir_requant_decim.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iir_requant_decim.sv
// Decimating requantizer for an IIR filter output: sums DECIM samples, rounds away
// SHIFT+log2(DECIM) fractional bits, saturates to OUT_WIDTH and queues results in a small FIFO.
module iir_requant_decim #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 11,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat_flag,
    output logic                 ovf_flag,
    input  logic                 clr_flags
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int AW    = IN_WIDTH + LOG2D;
    localparam int S     = SHIFT + LOG2D;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    localparam logic [LOG2D-1:0]  LAST_PHASE = LOG2D'(DECIM - 1);
    localparam logic signed [AW:0] HALF      = (AW + 1)'(64'sd1 <<< (S - 1));
    localparam logic signed [AW:0] MAXV      = (AW + 1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW:0] MINV      = (AW + 1)'(-(64'sd1 <<< (OUT_WIDTH - 1)));
    localparam logic [CW-1:0]      FULL_CNT  = CW'(FIFO_DEPTH);

    logic [LOG2D-1:0]     phase;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic                 s1_valid;
    logic signed [AW-1:0] s1_sum;

    logic signed [AW:0]          rnd_sum;
    logic signed [AW:0]          rnd_shift;
    logic [OUT_WIDTH-1:0]        s2_data;
    logic                        s2_clip;
    logic                        s2_valid;

    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;

    assign acc_next = acc + {{LOG2D{in_data[IN_WIDTH-1]}}, in_data};

    // Group accumulation; the completed group sum lands in stage 1 while acc restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= 1'b0;
            if (in_valid) begin
                if (phase == LAST_PHASE) begin
                    s1_valid <= 1'b1;
                    s1_sum   <= acc_next;
                    acc      <= '0;
                    phase    <= '0;
                end else begin
                    acc   <= acc_next;
                    phase <= phase + LOG2D'(1);
                end
            end
        end
    end

    // One guard bit above the sum keeps the rounding add from wrapping.
    assign rnd_sum   = {s1_sum[AW-1], s1_sum} + HALF;
    assign rnd_shift = rnd_sum >>> S;
    assign s2_valid  = s1_valid;

    always_comb begin
        s2_clip = 1'b0;
        s2_data = rnd_shift[OUT_WIDTH-1:0];
        if (rnd_shift > MAXV) begin
            s2_clip = 1'b1;
            s2_data = MAXV[OUT_WIDTH-1:0];
        end else if (rnd_shift < MINV) begin
            s2_clip = 1'b1;
            s2_data = MINV[OUT_WIDTH-1:0];
        end
    end

    // When full, wr_ptr equals rd_ptr, so a simultaneous pop frees exactly the slot being written.
    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = s2_valid & (~full | pop);
    assign drop      = s2_valid & full & ~pop;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= s2_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; a same-cycle event beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= (s2_valid & s2_clip) | (sat_flag & ~clr_flags);
            ovf_flag <= drop | (ovf_flag & ~clr_flags);
        end
    end

endmodule
